// File: rtl/shift_frame_capture.sv
// shift_frame_capture: hunts a sync byte in a parallel shift-register view and
// slices the following bit stream into bytes, queued in a small output FIFO.
// Ports: clk, rst_n (async, active-low), bit_stb/sr_word (shift-register view),
//   out_valid/out_ready/out_data/out_last (byte stream), locked, overflow,
//   ovf_clr, frame_err. Optional checksum byte: define CAPTURE_CHECKSUM_EN.
module shift_frame_capture #(
    parameter logic [7:0] SYNC_WORD  = 8'hA5,
    parameter int         FRAME_LEN  = 4,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_stb,
    input  logic [7:0] sr_word,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       locked,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic       frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0]    LAST_IDX = 8'(FRAME_LEN - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_PAYLOAD,
        ST_CHECK
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    byte_cnt_q, byte_cnt_d;
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [8:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic byte_done;
    logic is_last;
    logic push_req;
    logic push;
    logic pop;
    logic full;

    // Bit counter reaching 7 on a strobe means sr_word now holds a whole byte.
    assign byte_done = bit_stb && (bit_cnt_q == 3'd7);
    assign is_last   = (byte_cnt_q == LAST_IDX);
    assign push_req  = (state_q == ST_PAYLOAD) && byte_done;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_HUNT: begin
                if (bit_stb && (sr_word == SYNC_WORD)) state_d = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (byte_done && is_last) begin
`ifdef CAPTURE_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_HUNT;
`endif
                end
            end
            ST_CHECK: begin
                if (byte_done) state_d = ST_HUNT;
            end
            default: state_d = ST_HUNT;
        endcase
    end

    // Output logic
    always_comb begin
        locked = (state_q != ST_HUNT);
    end

    // Bit/byte counters
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        if (state_q == ST_HUNT) begin
            if (bit_stb && (sr_word == SYNC_WORD)) begin
                bit_cnt_d  = 3'd0;
                byte_cnt_d = 8'd0;
            end
        end else if (bit_stb) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (byte_done && (state_q == ST_PAYLOAD)) begin
                byte_cnt_d = byte_cnt_q + 8'd1;
            end
        end
    end

`ifdef CAPTURE_CHECKSUM_EN
    logic [7:0] chk_q, chk_d;
    logic       frame_err_q, frame_err_d;

    always_comb begin
        chk_d       = chk_q;
        frame_err_d = 1'b0;
        if ((state_q == ST_HUNT) && bit_stb && (sr_word == SYNC_WORD)) begin
            chk_d = 8'd0;
        end else if (push_req) begin
            chk_d = chk_q ^ sr_word;
        end else if ((state_q == ST_CHECK) && byte_done) begin
            frame_err_d = (sr_word != chk_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q       <= 8'd0;
            frame_err_q <= 1'b0;
        end else begin
            chk_q       <= chk_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    // FIFO: a full FIFO still accepts a push when the head leaves this cycle.
    assign full = (count_q == FULL_CNT);
    assign pop  = out_valid && out_ready;
    assign push = push_req && (!full || pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            mem_d[wr_ptr_q] = {is_last, sr_word};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as a clear leaves the flag set.
        if (push_req && !push) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 8'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 9'd0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q][7:0] : 8'd0;
    assign out_last  = out_valid ? mem_q[rd_ptr_q][8] : 1'b0;
    assign overflow  = overflow_q;

endmodule
